// File: rtl/fft_cfg_pkg.sv
// fft_cfg_pkg: shared config-word layout {scale_sch, forward} and FSM states for the FFT config channel.
package fft_cfg_pkg;
  localparam int CFG_W   = 9;
  localparam int SCALE_W = 8;
  localparam int FWD_BIT = 0;
  typedef enum logic {CFG_IDLE, CFG_APPLY} cfg_state_e;
  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic               fwd;
  } cfg_t;
  function automatic logic [CFG_W-1:0] cfg_pack(logic [SCALE_W-1:0] scale, logic fwd);
    return {scale, fwd};
  endfunction
  function automatic cfg_t cfg_unpack(logic [CFG_W-1:0] w);
    cfg_t c;
    c.scale = w[CFG_W-1:FWD_BIT+1];
    c.fwd   = w[FWD_BIT];
    return c;
  endfunction
endpackage

// File: rtl/fft_cfg_fifo.sv
// fft_cfg_fifo: synchronous FIFO with registered count; push ignored when full, pop ignored when empty.
module fft_cfg_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    count_d = (push_ok && !pop_ok) ? count_q + 1'b1 :
              (pop_ok && !push_ok) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr_q] <= din;
  assign dout  = mem[rd_ptr_q];
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/fft_config_rx.sv
// fft_config_rx: AXI-Stream config slave; buffers words and applies one per frame_start.
// FFT_CFG_RX_TLAST_CHECK_EN: drop beats with tlast=0 and pulse evt_tlast_err.
module fft_config_rx import fft_cfg_pkg::*; #(
  parameter int                 DEPTH         = 2,
  parameter logic [SCALE_W-1:0] DEFAULT_SCALE = 8'h00,
  parameter logic               DEFAULT_FWD   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [CFG_W-1:0]   s_axis_tdata,
  input  logic               s_axis_tlast,
  input  logic               frame_start,
  output logic [SCALE_W-1:0] scale_sch,
  output logic               forward,
  output logic               cfg_applied,
  output logic               cfg_pending,
  output logic               evt_tlast_err
);
  localparam int AW = $clog2(DEPTH);
  cfg_state_e       state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic             pend_q, pend_d;
  logic             accept, push, trigger, full, empty;
  logic [CFG_W-1:0] head;
  logic [AW:0]      count;
  assign accept = s_axis_tvalid && s_axis_tready;
`ifdef FFT_CFG_RX_TLAST_CHECK_EN
  logic evt_q;
  assign push = accept && s_axis_tlast;
  always_ff @(posedge clk)
    evt_q <= reset ? 1'b0 : accept && !s_axis_tlast;
  assign evt_tlast_err = evt_q;
`else
  logic unused_tlast;
  assign unused_tlast  = s_axis_tlast;
  assign push          = accept;
  assign evt_tlast_err = 1'b0;
`endif
  fft_cfg_fifo #(.W(CFG_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .din(s_axis_tdata), .pop(trigger),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  // A frame_start seen during APPLY is held one cycle so it is not lost.
  always_comb begin
    trigger = state_q == CFG_IDLE && (frame_start || pend_q) && !empty;
    state_d = trigger ? CFG_APPLY : CFG_IDLE;
    pend_d  = state_q == CFG_APPLY && frame_start;
    cfg_d   = trigger ? cfg_unpack(head) : cfg_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CFG_IDLE;
      pend_q  <= 1'b0;
      cfg_q   <= cfg_unpack(cfg_pack(DEFAULT_SCALE, DEFAULT_FWD));
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cfg_q   <= cfg_d;
    end
  end
  assign s_axis_tready = !full;
  assign scale_sch     = cfg_q.scale;
  assign forward       = cfg_q.fwd;
  assign cfg_applied   = state_q == CFG_APPLY;
  assign cfg_pending   = count != '0;
endmodule
